lcd1602_ctrl: RTL and testbench

LCD1602_CTRL -- requirements
Module: lcd1602_ctrl

---
 rtl/lcd1602_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lcd1602_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd1602_ctrl
// Description : HD44780/LCD1602 8-bit write-only controller with power-on init
//               and a valid/ready byte interface.
// Revision    : 1.0
// ============================================================================
module lcd1602_ctrl #(
    parameter int INIT_WAIT = 750000,
    parameter int EN_HIGH   = 25,
    parameter int CMD_WAIT  = 2500,
    parameter int CLR_WAIT  = 82000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       LCD_EN,
    output logic       RS,
    output logic       RW,
    output logic [7:0] DB8
);

    localparam int c_MAX_A   = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
    localparam int c_MAX_B   = (EN_HIGH > CMD_WAIT) ? EN_HIGH : CMD_WAIT;
    localparam int c_MAX_CNT = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);

    localparam logic [c_CNT_W-1:0] c_INIT_LD = c_CNT_W'(INIT_WAIT);
    localparam logic [c_CNT_W-1:0] c_EN_LD   = c_CNT_W'(EN_HIGH);
    localparam logic [c_CNT_W-1:0] c_CMD_LD  = c_CNT_W'(CMD_WAIT);
    localparam logic [c_CNT_W-1:0] c_CLR_LD  = c_CNT_W'(CLR_WAIT);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    typedef enum logic [2:0] {
        PWR   = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        WAIT  = 3'd3,
        IDLE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [1:0]         r_idx;
    logic [1:0]         w_idx_nxt;
    logic               r_rs;
    logic               w_rs_nxt;
    logic [7:0]         r_data;
    logic [7:0]         w_data_nxt;
    logic               r_en;
    logic               w_en_nxt;
    logic               r_ready;
    logic               w_ready_nxt;
    logic               r_init_done;
    logic               w_init_done_nxt;
    logic               w_cnt_last;
    logic               w_long_wait;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h38;
            2'd1:    cmd = 8'h0C;
            2'd2:    cmd = 8'h06;
            default: cmd = 8'h01;
        endcase
        return cmd;
    endfunction

    assign w_cnt_last = (r_cnt <= c_ONE);

    // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
    assign w_long_wait = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) || (r_data == 8'h03));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= PWR;
            r_cnt       <= c_INIT_LD;
            r_idx       <= 2'd0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_en        <= 1'b0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_rs        <= w_rs_nxt;
            r_data      <= w_data_nxt;
            r_en        <= w_en_nxt;
            r_ready     <= w_ready_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_rs_nxt        = r_rs;
        w_data_nxt      = r_data;
        w_init_done_nxt = r_init_done;

        case (r_state)
            PWR: begin
                if (w_cnt_last) begin
                    w_state_nxt = SETUP;
                    w_idx_nxt   = 2'd0;
                    w_rs_nxt    = 1'b0;
                    w_data_nxt  = init_cmd(2'd0);
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end
            end
            SETUP: begin
                w_state_nxt = PULSE;
                w_cnt_nxt   = c_EN_LD;
            end
            PULSE: begin
                if (w_cnt_last) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = w_long_wait ? c_CLR_LD : c_CMD_LD;
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end
            end
            WAIT: begin
                if (w_cnt_last) begin
                    if (!r_init_done && (r_idx != 2'd3)) begin
                        w_state_nxt = SETUP;
                        w_idx_nxt   = r_idx + 2'd1;
                        w_rs_nxt    = 1'b0;
                        w_data_nxt  = init_cmd(r_idx + 2'd1);
                    end else begin
                        w_state_nxt     = IDLE;
                        w_init_done_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end
            end
            IDLE: begin
                if (req_valid && r_ready) begin
                    w_state_nxt = SETUP;
                    w_rs_nxt    = req_rs;
                    w_data_nxt  = req_data;
                end
            end
            default: begin
                w_state_nxt = PWR;
                w_cnt_nxt   = c_INIT_LD;
            end
        endcase

        // Strobe and ready are registered decodes of the upcoming state.
        w_en_nxt    = (w_state_nxt == PULSE);
        w_ready_nxt = (w_state_nxt == IDLE);
    end

    assign req_ready = r_ready;
    assign init_done = r_init_done;
    assign LCD_EN    = r_en;
    assign RS        = r_rs;
    assign RW        = 1'b0;
    assign DB8       = r_data;

endmodule
`default_nettype wire

// File: tb/tb_lcd1602_ctrl.sv
`default_nettype none
// Self-checking bench for lcd1602_ctrl with shortened timing parameters.
module tb_lcd1602_ctrl;

    localparam int c_INIT_WAIT = 10;
    localparam int c_EN_HIGH   = 2;
    localparam int c_CMD_WAIT  = 4;
    localparam int c_CLR_WAIT  = 8;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rs    = 1'b0;
    logic [7:0] req_data  = 8'h00;
    logic       req_ready;
    logic       init_done;
    logic       LCD_EN;
    logic       RS;
    logic       RW;
    logic [7:0] DB8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    lcd1602_ctrl #(
        .INIT_WAIT (c_INIT_WAIT),
        .EN_HIGH   (c_EN_HIGH),
        .CMD_WAIT  (c_CMD_WAIT),
        .CLR_WAIT  (c_CLR_WAIT)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .init_done (init_done),
        .LCD_EN    (LCD_EN),
        .RS        (RS),
        .RW        (RW),
        .DB8       (DB8)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Pulse monitor: records RS/DB8/width of every completed LCD_EN pulse.
    logic [7:0] pq_db[$];
    logic       pq_rs[$];
    int         pq_w[$];
    logic       mon_in = 1'b0;
    logic       mon_rs;
    logic [7:0] mon_db;
    int         mon_w;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            mon_in = 1'b0;
        end else begin
            check("rw_zero", 32'(RW), 32'd0);
            if (LCD_EN) begin
                if (!mon_in) begin
                    mon_in = 1'b1;
                    mon_rs = RS;
                    mon_db = DB8;
                    mon_w  = 1;
                end else begin
                    mon_w++;
                    check("bus_stable_in_pulse", {23'd0, RS, DB8}, {23'd0, mon_rs, mon_db});
                end
            end else if (mon_in) begin
                mon_in = 1'b0;
                pq_db.push_back(mon_db);
                pq_rs.push_back(mon_rs);
                pq_w.push_back(mon_w);
            end
        end
    end

    task automatic clear_pulses();
        pq_db.delete();
        pq_rs.delete();
        pq_w.delete();
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        check(name, 32'(req_ready), 32'd1);
    endtask

    // Expects reset asserted on entry; releases it and checks the whole init.
    task automatic run_init(input string tag);
        int         first_done;
        int         first_ready;
        logic [7:0] init_exp [4];
        init_exp    = '{8'h38, 8'h0C, 8'h06, 8'h01};
        first_done  = 0;
        first_ready = 0;
        check({tag, "_rst_lcd_en"}, 32'(LCD_EN), 32'd0);
        check({tag, "_rst_rs"}, 32'(RS), 32'd0);
        check({tag, "_rst_rw"}, 32'(RW), 32'd0);
        check({tag, "_rst_db8"}, 32'(DB8), 32'd0);
        check({tag, "_rst_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rst_init_done"}, 32'(init_done), 32'd0);
        clear_pulses();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (e == 3) begin
                req_valid = 1'b1;
                req_rs    = 1'b1;
                req_data  = 8'h55;
            end
            if (e == 5) req_valid = 1'b0;
            if (init_done && first_done == 0) first_done = e;
            if (req_ready && first_ready == 0) first_ready = e;
        end
        check({tag, "_init_done_edge"}, first_done, 42);
        check({tag, "_ready_edge"}, first_ready, 42);
        check({tag, "_pulse_count"}, pq_db.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (pq_db.size() > i) begin
                check($sformatf("%s_init%0d_db8", tag, i), 32'(pq_db[i]), 32'(init_exp[i]));
                check($sformatf("%s_init%0d_rs", tag, i), 32'(pq_rs[i]), 32'd0);
                check($sformatf("%s_init%0d_width", tag, i), pq_w[i], c_EN_HIGH);
            end
        end
    endtask

    // Drive one request on the first ready cycle; measure edges from accept to ready.
    task automatic send(input logic rs, input logic [7:0] data, output int lat);
        wait_ready("ready_before_send");
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = data;
        tick();
        req_valid = 1'b0;
        req_rs    = ~rs;
        req_data  = ~data;
        lat = 0;
        while (!req_ready && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         lat;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] expq[$];
    int         lat;

    initial begin
        vecs[0] = '{1'b1, 8'h41, 7};
        vecs[1] = '{1'b0, 8'h01, 11};
        vecs[2] = '{1'b1, 8'h01, 7};
        vecs[3] = '{1'b0, 8'h02, 11};
        vecs[4] = '{1'b0, 8'h03, 11};
        vecs[5] = '{1'b0, 8'h04, 7};
        vecs[6] = '{1'b0, 8'h00, 7};
        vecs[7] = '{1'b1, 8'hFF, 7};
        vecs[8] = '{1'b0, 8'h38, 7};

        repeat (3) tick();
        run_init("pwr");

        for (int i = 0; i < 9; i++) begin
            clear_pulses();
            send(vecs[i].rs, vecs[i].data, lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_pulses", i), pq_db.size(), 1);
            if (pq_db.size() > 0) begin
                check($sformatf("vec%0d_db8", i), 32'(pq_db[0]), 32'(vecs[i].data));
                check($sformatf("vec%0d_rs", i), 32'(pq_rs[0]), 32'(vecs[i].rs));
                check($sformatf("vec%0d_width", i), pq_w[0], c_EN_HIGH);
            end
            check($sformatf("vec%0d_idle_db8", i), 32'(DB8), 32'(vecs[i].data));
            check($sformatf("vec%0d_idle_rs", i), 32'(RS), 32'(vecs[i].rs));
        end

        // Busy ignore: valid with 0x55 while the previous byte is pulsing.
        clear_pulses();
        wait_ready("busy_ready");
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h41;
        tick();
        req_valid = 1'b0;
        tick();
        check("busy_in_pulse", 32'(LCD_EN), 32'd1);
        req_valid = 1'b1;
        req_rs    = 1'b0;
        req_data  = 8'h55;
        tick();
        tick();
        req_valid = 1'b0;
        wait_ready("busy_ready_back");
        repeat (3) tick();
        check("busy_pulse_count", pq_db.size(), 1);
        if (pq_db.size() > 0) check("busy_db8", 32'(pq_db[0]), 32'h41);

        // Continuous valid with data changing every cycle.
        clear_pulses();
        expq.delete();
        req_valid = 1'b1;
        req_rs    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            req_data = 8'h60 + 8'(i);
            if (req_ready) expq.push_back(req_data);
            tick();
        end
        req_valid = 1'b0;
        wait_ready("stream_ready_back");
        repeat (2) tick();
        check("stream_accepts", expq.size(), 5);
        check("stream_pulse_count", pq_db.size(), expq.size());
        for (int i = 0; i < 5; i++) begin
            if (pq_db.size() > i && expq.size() > i)
                check($sformatf("stream%0d_db8", i), 32'(pq_db[i]), 32'(expq[i]));
        end

        // Reset asserted mid-pulse, then full init rerun.
        wait_ready("rst_ready");
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h5A;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!LCD_EN && lat < 20) begin
            tick();
            lat++;
        end
        check("rst_saw_pulse", 32'(LCD_EN), 32'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("rst_async_en", 32'(LCD_EN), 32'd0);
        check("rst_async_db8", 32'(DB8), 32'd0);
        repeat (2) tick();
        run_init("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
